// File: rtl/dff_pe_as.sv
// dff_pe_as: D flip-flop with asynchronous active-low reset and selectable clock edge.
//
// Parameters:
//   WIDTH    data width, 1..64
//   RST_VAL  value loaded while reset is asserted (truncated to WIDTH bits)
//   NEG_EDGE 0: capture on rising edge, 1: capture on falling edge
//
// Ports (positional order q, d, clk, rst, qn [, se, si, so]):
//   q   out WIDTH  registered data
//   d   in  WIDTH  data captured on the active edge
//   clk in  1      clock
//   rst in  1      asynchronous reset, active low
//   qn  out WIDTH  bitwise inverse of q
//   se  in  1      scan enable        (DFF_PE_AS_SCAN_EN only)
//   si  in  1      scan serial input  (DFF_PE_AS_SCAN_EN only)
//   so  out 1      scan serial output (DFF_PE_AS_SCAN_EN only)
//
// Optional feature macro: DFF_PE_AS_SCAN_EN adds the se/si/so scan chain ports.
module dff_pe_as #(
    parameter int unsigned WIDTH    = 1,
    parameter logic [63:0] RST_VAL  = 64'd0,
    parameter bit          NEG_EDGE = 1'b0
) (
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] qn
`ifdef DFF_PE_AS_SCAN_EN
    ,
    input  logic             se,
    input  logic             si,
    output logic             so
`endif
);

    localparam logic [WIDTH-1:0] RST_Q = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

`ifdef DFF_PE_AS_SCAN_EN
    // Shift toward the MSB with si entering at bit 0; for WIDTH=1 the shift
    // leaves zero so the result is just si.
    always_comb begin
        q_d = se ? ((q_q << 1) | WIDTH'(si)) : d;
    end

    assign so = q_q[WIDTH-1];
`else
    always_comb begin
        q_d = d;
    end
`endif

    // Only one of these flop flavours is elaborated, chosen by NEG_EDGE.
    generate
        if (NEG_EDGE) begin : g_neg
            always_ff @(negedge clk or negedge rst) begin
                if (!rst) q_q <= RST_Q;
                else      q_q <= q_d;
            end
        end else begin : g_pos
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) q_q <= RST_Q;
                else      q_q <= q_d;
            end
        end
    endgenerate

    assign q  = q_q;
    assign qn = ~q_q;

endmodule

// File: tb/tb_dff_pe_as.sv
// tb_dff_pe_as: directed self-checking bench for dff_pe_as (both edge flavours, wide reset value, scan option).
module tb_dff_pe_as;

    int tests = 0;
    int fails = 0;

    // Hand-driven clock/reset/data for the two 1-bit instances.
    logic sclk, srst, sd;
    logic pe_q, pe_qn, ne_q, ne_qn;

    // Free-running clock for the wide instance (and scan instance).
    logic       clk = 1'b0;
    logic       rst8;
    logic [7:0] d8 = 8'h00;
    logic [7:0] q8, qn8;

    always #5 clk = ~clk;

`ifdef DFF_PE_AS_SCAN_EN
    logic [3:0] dsc = 4'h0;
    logic [3:0] qsc, qnsc;
    logic       se = 1'b0, si = 1'b0;
    logic       so, pe_so, ne_so, so8;
`endif

    dff_pe_as #(.WIDTH(1), .RST_VAL(64'd0), .NEG_EDGE(1'b0)) u_pe (
        .q(pe_q), .d(sd), .clk(sclk), .rst(srst), .qn(pe_qn)
`ifdef DFF_PE_AS_SCAN_EN
        , .se(1'b0), .si(1'b0), .so(pe_so)
`endif
    );

    dff_pe_as #(.WIDTH(1), .RST_VAL(64'd0), .NEG_EDGE(1'b1)) u_ne (
        .q(ne_q), .d(sd), .clk(sclk), .rst(srst), .qn(ne_qn)
`ifdef DFF_PE_AS_SCAN_EN
        , .se(1'b0), .si(1'b0), .so(ne_so)
`endif
    );

    dff_pe_as #(.WIDTH(8), .RST_VAL(64'hA5), .NEG_EDGE(1'b0)) u_w8 (
        .q(q8), .d(d8), .clk(clk), .rst(rst8), .qn(qn8)
`ifdef DFF_PE_AS_SCAN_EN
        , .se(1'b0), .si(1'b0), .so(so8)
`endif
    );

`ifdef DFF_PE_AS_SCAN_EN
    dff_pe_as #(.WIDTH(4), .RST_VAL(64'd0), .NEG_EDGE(1'b0)) u_sc (
        .q(qsc), .d(dsc), .clk(clk), .rst(rst8), .qn(qnsc),
        .se(se), .si(si), .so(so)
    );
`endif

    // {rst,clk,d} stepped 0..7: both flavours must read 0 at every step.
    task automatic test_sweep();
        logic [2:0] v;
        for (int s = 0; s < 8; s++) begin
            v = 3'(s);
            {srst, sclk, sd} = v;
            #5;
            tests++; if (pe_q !== 1'b0) begin fails++; $display("FAIL sweep_pe step %0d: got %b want 0", s, pe_q); end
            tests++; if (pe_qn !== 1'b1) begin fails++; $display("FAIL sweep_pe_qn step %0d: got %b want 1", s, pe_qn); end
            tests++; if (ne_q !== 1'b0) begin fails++; $display("FAIL sweep_ne step %0d: got %b want 0", s, ne_q); end
            #5;
        end
    endtask

    // Rising edge moves only the rising-edge flop; falling edge moves the other.
    task automatic test_edge_select();
        sd = 1'b0;
        #1 sclk = 1'b0;
        #1 sd = 1'b1;
        #1 sclk = 1'b1;
        #1;
        tests++; if (ne_q !== 1'b0) begin fails++; $display("FAIL edge_ne_rise: got %b want 0", ne_q); end
        tests++; if (pe_q !== 1'b1) begin fails++; $display("FAIL edge_pe_rise: got %b want 1", pe_q); end
        tests++; if (pe_qn !== 1'b0) begin fails++; $display("FAIL edge_pe_qn: got %b want 0", pe_qn); end
        #1 sclk = 1'b0;
        #1;
        tests++; if (ne_q !== 1'b1) begin fails++; $display("FAIL edge_ne_fall: got %b want 1", ne_q); end
        tests++; if (ne_qn !== 1'b0) begin fails++; $display("FAIL edge_ne_qn: got %b want 0", ne_qn); end
        tests++; if (pe_q !== 1'b1) begin fails++; $display("FAIL edge_pe_fall_hold: got %b want 1", pe_q); end
        sd = 1'b0;
        #1;
        tests++; if (pe_q !== 1'b1 || ne_q !== 1'b1) begin fails++; $display("FAIL d_change_hold: got pe=%b ne=%b want 1 1", pe_q, ne_q); end
    endtask

    // Asynchronous assertion, clocks ignored in reset, release coinciding with an edge.
    task automatic test_async_reset();
        #1 srst = 1'b0;
        #1;
        tests++; if (pe_q !== 1'b0 || pe_qn !== 1'b1) begin fails++; $display("FAIL async_pe: got q=%b qn=%b want 0 1", pe_q, pe_qn); end
        tests++; if (ne_q !== 1'b0 || ne_qn !== 1'b1) begin fails++; $display("FAIL async_ne: got q=%b qn=%b want 0 1", ne_q, ne_qn); end
        sd = 1'b1;
        repeat (2) begin
            #1 sclk = 1'b1;
            #1 sclk = 1'b0;
        end
        #1;
        tests++; if (pe_q !== 1'b0 || ne_q !== 1'b0) begin fails++; $display("FAIL reset_hold: got pe=%b ne=%b want 0 0", pe_q, ne_q); end
        srst = 1'b1;
        sclk = 1'b1;
        #1;
        tests++; if (pe_q !== 1'b1) begin fails++; $display("FAIL release_rise_pe: got %b want 1", pe_q); end
        tests++; if (ne_q !== 1'b0) begin fails++; $display("FAIL release_rise_ne: got %b want 0", ne_q); end
        #1 srst = 1'b0;
        #1;
        srst = 1'b1;
        sclk = 1'b0;
        #1;
        tests++; if (ne_q !== 1'b1) begin fails++; $display("FAIL release_fall_ne: got %b want 1", ne_q); end
        tests++; if (pe_q !== 1'b0) begin fails++; $display("FAIL release_fall_pe: got %b want 0", pe_q); end
    endtask

    // 8-bit instance with reset value A5 on the free-running clock.
    task automatic test_width8();
        @(negedge clk);
        tests++; if (q8 !== 8'hA5 || qn8 !== 8'h5A) begin fails++; $display("FAIL w8_reset: got q=%h qn=%h want a5 5a", q8, qn8); end
        rst8 = 1'b1;
        d8 = 8'h3C;
        @(negedge clk);
        tests++; if (q8 !== 8'h3C || qn8 !== 8'hC3) begin fails++; $display("FAIL w8_capture: got q=%h qn=%h want 3c c3", q8, qn8); end
        d8 = 8'hFF;
        #2;
        tests++; if (q8 !== 8'h3C) begin fails++; $display("FAIL w8_no_edge: got %h want 3c", q8); end
        @(negedge clk);
        tests++; if (q8 !== 8'hFF) begin fails++; $display("FAIL w8_next: got %h want ff", q8); end
        #2 rst8 = 1'b0;
        #1;
        tests++; if (q8 !== 8'hA5) begin fails++; $display("FAIL w8_midreset: got %h want a5", q8); end
        @(negedge clk);
        tests++; if (q8 !== 8'hA5) begin fails++; $display("FAIL w8_reset_ignores_clk: got %h want a5", q8); end
        rst8 = 1'b1;
        d8 = 8'h11;
        @(negedge clk);
        tests++; if (q8 !== 8'h11) begin fails++; $display("FAIL w8_after_release: got %h want 11", q8); end
    endtask

`ifdef DFF_PE_AS_SCAN_EN
    task automatic test_scan();
        logic [3:0] bits;
        logic [3:0] exp [4];
        bits = 4'b1011;
        exp = '{4'h1, 4'h2, 4'h5, 4'hB};
        rst8 = 1'b0;
        #1;
        tests++; if (qsc !== 4'h0) begin fails++; $display("FAIL scan_reset: got %h want 0", qsc); end
        @(negedge clk);
        rst8 = 1'b1;
        se = 1'b1;
        for (int i = 0; i < 4; i++) begin
            si = bits[3-i];
            @(negedge clk);
            tests++; if (qsc !== exp[i]) begin fails++; $display("FAIL scan_shift %0d: got %h want %h", i, qsc, exp[i]); end
        end
        tests++; if (so !== 1'b1) begin fails++; $display("FAIL scan_so: got %b want 1", so); end
        se = 1'b0;
        dsc = 4'h6;
        @(negedge clk);
        tests++; if (qsc !== 4'h6 || so !== 1'b0) begin fails++; $display("FAIL scan_off: got q=%h so=%b want 6 0", qsc, so); end
        tests++; if (pe_so !== pe_q || ne_so !== ne_q || so8 !== q8[7]) begin fails++; $display("FAIL scan_so_others: got %b %b %b want %b %b %b", pe_so, ne_so, so8, pe_q, ne_q, q8[7]); end
        se = 1'b1;
        #2 rst8 = 1'b0;
        #1;
        tests++; if (qsc !== 4'h0) begin fails++; $display("FAIL scan_reset_priority: got %h want 0", qsc); end
        rst8 = 1'b1;
        se = 1'b0;
    endtask
`endif

    initial begin
        srst = 1'b1;
        sclk = 1'b0;
        sd   = 1'b0;
        rst8 = 1'b1;
        #1;
        rst8 = 1'b0;
        test_sweep();
        test_edge_select();
        test_async_reset();
        test_width8();
`ifdef DFF_PE_AS_SCAN_EN
        test_scan();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dff_pe_as.md
DFF_PE_AS -- requirements
Module: dff_pe_as

Interface
REQ-001 Parameter WIDTH, default 1: data width in bits, legal range 1..64.
REQ-002 Parameter RST_VAL, default 0: value loaded into q during reset, truncated to WIDTH bits.
REQ-003 Parameter NEG_EDGE, default 0: active clock edge; 0 selects rising edge (the dff_Pe_As flavour), 1 selects falling edge (the dff_Ne_As flavour).
REQ-004 clk  input  1  single clock; all state changes except reset occur on the edge selected by NEG_EDGE.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 d  input  WIDTH  data captured on the active edge.
REQ-007 q  output  WIDTH  registered data.
REQ-008 qn  output  WIDTH  bitwise inverse of q.
REQ-009 Positional port order SHALL be q, d, clk, rst, qn, followed by any macro-enabled ports, so that a 4-port positional instance (q,d,clk,rst) connects correctly.

Function
REQ-010 On each active edge with rst=1, q SHALL take the value of d sampled at that edge, with zero-latency visibility after the edge (one register stage).
REQ-011 The inactive clock edge and changes of d between active edges SHALL NOT change q.
REQ-012 qn SHALL equal ~q at all times, including during reset, with no extra register stage.
REQ-013 When rst deasserts in the same timestep as an active edge, the edge SHALL capture d.
REQ-014 After power-up and before the first reset or active edge, q is unknown; no initial value SHALL be relied on.
REQ-015 All WIDTH bits SHALL update together; no per-bit enables.

Reset
REQ-016 rst=0 SHALL force q=RST_VAL and qn=~RST_VAL immediately, without waiting for a clock edge.
REQ-017 While rst=0, clock edges SHALL be ignored and q SHALL hold RST_VAL.
REQ-018 Reset asserted mid-operation SHALL override any pending capture; the first capture after release occurs on the next active edge with rst=1.

Configuration
REQ-019 Macro DFF_PE_AS_SCAN_EN: when defined, the module SHALL add input se (1 bit), input si (1 bit) and output so (1 bit), appended after qn.
REQ-020 With DFF_PE_AS_SCAN_EN defined and se=1, an active edge SHALL load q with {q[WIDTH-2:0], si}, or with si when WIDTH=1; so SHALL equal q[WIDTH-1]; reset SHALL still take priority.
REQ-021 With DFF_PE_AS_SCAN_EN defined and se=0, behaviour SHALL be identical to the non-scan build.
REQ-022 Without DFF_PE_AS_SCAN_EN, the se, si and so ports SHALL NOT exist.

Verification
REQ-023 NEG_EDGE=0, WIDTH=1: step {rst,clk,d} through 0..7 at 10 ns per step -> q=0 for steps 0-3 (reset); q=0 through steps 4-7, because the rising edge at step 6 samples d=0.
REQ-024 NEG_EDGE=1, WIDTH=1: same sweep -> q=0 throughout; the falling edge at step 4 coincides with reset release and captures d=0.
REQ-025 NEG_EDGE=0: rst=1, d=1, rising edge -> q=1, qn=0; then drive rst=0 between edges -> q=0 immediately, with no clock edge.
REQ-026 WIDTH=8, RST_VAL=8'hA5: reset -> q=8'hA5; release rst, d=8'h3C, one active edge -> q=8'h3C; then change d with no edge -> q unchanged.
REQ-027 NEG_EDGE=1: d=1 and a rising edge -> q unchanged; then a falling edge -> q=1.
REQ-028 Scan build, WIDTH=4: reset (q=0), se=1, shift si=1,0,1,1 over 4 edges -> q=4'b1011, so=1.
